// File: rtl/vu_commit_unit.sv
// vu_commit_unit: in-order commit tracker between the scalar issue path and
// the vector lanes. It records each issued instruction with its lane mask and
// collects per-lane commit pulses. An entry retires once every lane in its
// mask has committed, and then the scalar unit gets one registered commit
// pulse per instruction, in issue order.
module vu_commit_unit #(
  parameter int NUM_LANES   = 16,
  parameter int DEPTH       = 8,
  parameter int WIDTH_ISSUE = 7,
  parameter int WIDTH_CNT   = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Issue,
  input  logic [WIDTH_ISSUE-1:0] I_Issue_No,
  input  logic [NUM_LANES-1:0]   I_Lane_Mask,
  input  logic [NUM_LANES-1:0]   I_Lane_Commit,
  output logic                   O_Full,
  output logic                   O_Empty,
  output logic [WIDTH_CNT-1:0]   O_Count,
  output logic                   O_Commit,
  output logic [WIDTH_ISSUE-1:0] O_Commit_No,
  output logic [1:0]             O_Error
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [DEPTH-1:0]       valid;
  logic [WIDTH_ISSUE-1:0] issue_no [DEPTH];
  logic [NUM_LANES-1:0]   mask     [DEPTH];
  logic [NUM_LANES-1:0]   done     [DEPTH];

  logic [NUM_LANES-1:0]   done_set [DEPTH];
  logic [NUM_LANES-1:0]   lane_hit;
  logic [PTR_W-1:0]       slot;
  logic                   spurious;
  logic                   issue_ok;
  logic                   retire;
  logic [WIDTH_CNT-1:0]   count_next;

  // Per-lane search for the oldest outstanding entry still waiting on that
  // lane. Valid entries are contiguous from head, so the walk covers only
  // O_Count slots. An entry issued this cycle is not valid yet, so a commit
  // can reach it from the next cycle onwards.
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      done_set[e] = '0;
    end
    lane_hit = '0;
    slot     = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot = PTR_W'(32'(head) + i);
        if (I_Lane_Commit[l] && !lane_hit[l] && (i < 32'(O_Count)) &&
            mask[slot][l] && !done[slot][l]) begin
          done_set[slot][l] = 1'b1;
          lane_hit[l]       = 1'b1;
        end
      end
    end
    spurious = |(I_Lane_Commit & ~lane_hit);
  end

  // Issue acceptance, head retire decision and next occupancy.
  always_comb begin
    issue_ok   = I_Issue && !O_Full;
    retire     = valid[head] && (done[head] == mask[head]);
    count_next = O_Count + WIDTH_CNT'(issue_ok) - WIDTH_CNT'(retire);
  end

  // Table storage, pointers, occupancy flags, commit pulse and sticky errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      valid       <= '0;
      O_Count     <= '0;
      O_Full      <= 1'b0;
      O_Empty     <= 1'b1;
      O_Commit    <= 1'b0;
      O_Commit_No <= '0;
      O_Error     <= '0;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        done[e] <= done[e] | done_set[e];
      end
      // The tail slot is never valid when an issue is accepted, so this
      // later write of done takes priority over the OR update above.
      if (issue_ok) begin
        issue_no[tail] <= I_Issue_No;
        mask[tail]     <= I_Lane_Mask;
        done[tail]     <= '0;
        valid[tail]    <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
        O_Commit    <= 1'b1;
        O_Commit_No <= issue_no[head];
      end else begin
        O_Commit    <= 1'b0;
      end
      O_Count    <= count_next;
      O_Full     <= (count_next == WIDTH_CNT'(DEPTH));
      O_Empty    <= (count_next == '0);
      O_Error[0] <= O_Error[0] | spurious;
      O_Error[1] <= O_Error[1] | (I_Issue && O_Full);
    end
  end

endmodule

// File: tb/tb_vu_commit_unit.sv
// Directed bench for vu_commit_unit with hand-computed expectations.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, and retired numbers are logged on the falling edge.
module tb_vu_commit_unit;

  logic        clock;
  logic        reset;
  logic        I_Issue;
  logic [6:0]  I_Issue_No;
  logic [15:0] I_Lane_Mask;
  logic [15:0] I_Lane_Commit;
  logic        O_Full;
  logic        O_Empty;
  logic [3:0]  O_Count;
  logic        O_Commit;
  logic [6:0]  O_Commit_No;
  logic [1:0]  O_Error;

  int checks   = 0;
  int failures = 0;
  int cq[$];

  vu_commit_unit #(
    .NUM_LANES  (16),
    .DEPTH      (8),
    .WIDTH_ISSUE(7)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Issue      (I_Issue),
    .I_Issue_No   (I_Issue_No),
    .I_Lane_Mask  (I_Lane_Mask),
    .I_Lane_Commit(I_Lane_Commit),
    .O_Full       (O_Full),
    .O_Empty      (O_Empty),
    .O_Count      (O_Count),
    .O_Commit     (O_Commit),
    .O_Commit_No  (O_Commit_No),
    .O_Error      (O_Error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log of every retired issue number.
  always @(negedge clock) begin
    if (!reset && O_Commit) cq.push_back(int'(O_Commit_No));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int i);
    if (i < cq.size()) return cq[i];
    return -1;
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Present one cycle of inputs; returns 1 ns after the edge that sampled them.
  task automatic drive(input logic iss, input logic [6:0] no, input logic [15:0] msk,
                       input logic [15:0] cmt);
    I_Issue       = iss;
    I_Issue_No    = no;
    I_Lane_Mask   = msk;
    I_Lane_Commit = cmt;
    cycle();
    I_Issue       = 1'b0;
    I_Issue_No    = '0;
    I_Lane_Mask   = '0;
    I_Lane_Commit = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_full"},  32'(O_Full),      32'd0);
    check({tag, "_empty"}, 32'(O_Empty),     32'd1);
    check({tag, "_count"}, 32'(O_Count),     32'd0);
    check({tag, "_cmt"},   32'(O_Commit),    32'd0);
    check({tag, "_cno"},   32'(O_Commit_No), 32'd0);
    check({tag, "_err"},   32'(O_Error),     32'd0);
  endtask

  initial begin
    reset = 1'b1;
    I_Issue = 1'b0; I_Issue_No = '0; I_Lane_Mask = '0; I_Lane_Commit = '0;
    cycle();
    cycle();
    check_reset_state("rst");
    reset = 1'b0;

    // Basic: one instruction on lanes 0-3, the last lane commits at edge t.
    cq.delete();
    drive(1'b1, 7'd5, 16'h000F, '0);
    check("basic_count", 32'(O_Count), 32'd1);
    check("basic_empty", 32'(O_Empty), 32'd0);
    drive(1'b0, '0, '0, 16'h0001);
    drive(1'b0, '0, '0, 16'h0002);
    drive(1'b0, '0, '0, 16'h0004);
    drive(1'b0, '0, '0, 16'h0008);
    check("basic_t_cmt", 32'(O_Commit), 32'd0);
    cycle();
    check("basic_t1_cmt", 32'(O_Commit), 32'd1);
    check("basic_t1_no", 32'(O_Commit_No), 32'd5);
    check("basic_t1_empty", 32'(O_Empty), 32'd1);
    cycle();
    check("basic_t2_cmt", 32'(O_Commit), 32'd0);
    check("basic_log", 32'(cq.size()), 32'd1);

    // Ordering: No=2 finishes its lanes first but must follow No=1.
    cq.delete();
    drive(1'b1, 7'd1, 16'h0003, '0);
    drive(1'b1, 7'd2, 16'h0001, '0);
    drive(1'b0, '0, '0, 16'h0001);
    drive(1'b0, '0, '0, 16'h0001);
    cycle();
    check("ord_hold_cmt", 32'(O_Commit), 32'd0);
    check("ord_hold_cnt", 32'(O_Count), 32'd2);
    drive(1'b0, '0, '0, 16'h0002);
    check("ord_t_cmt", 32'(O_Commit), 32'd0);
    cycle();
    check("ord_first_cmt", 32'(O_Commit), 32'd1);
    check("ord_first_no", 32'(O_Commit_No), 32'd1);
    cycle();
    check("ord_second_cmt", 32'(O_Commit), 32'd1);
    check("ord_second_no", 32'(O_Commit_No), 32'd2);
    cycle();
    check("ord_done_cmt", 32'(O_Commit), 32'd0);
    check("ord_done_empty", 32'(O_Empty), 32'd1);
    check("ord_log_n", 32'(cq.size()), 32'd2);
    check("ord_log0", 32'(qat(0)), 32'd1);
    check("ord_log1", 32'(qat(1)), 32'd2);

    // Mask zero: retires one edge after issue without lane activity.
    cq.delete();
    drive(1'b1, 7'd9, 16'h0000, '0);
    check("mz_t_cmt", 32'(O_Commit), 32'd0);
    check("mz_t_cnt", 32'(O_Count), 32'd1);
    cycle();
    check("mz_cmt", 32'(O_Commit), 32'd1);
    check("mz_no", 32'(O_Commit_No), 32'd9);
    check("mz_cnt", 32'(O_Count), 32'd0);
    cycle();
    check("mz_log_n", 32'(cq.size()), 32'd1);

    // Full/overflow: the table is filled across the pointer wrap (tail starts at 4).
    cq.delete();
    for (int n = 0; n < 8; n++) drive(1'b1, 7'(n), 16'hFFFF, '0);
    check("full_flag", 32'(O_Full), 32'd1);
    check("full_cnt", 32'(O_Count), 32'd8);
    check("full_err_pre", 32'(O_Error), 32'd0);
    drive(1'b1, 7'd8, 16'hFFFF, '0);
    check("ovf_cnt", 32'(O_Count), 32'd8);
    check("ovf_err", 32'(O_Error), 32'd2);
    for (int n = 0; n < 8; n++) drive(1'b0, '0, '0, 16'hFFFF);
    cycle();
    cycle();
    check("drain_cnt", 32'(O_Count), 32'd0);
    check("drain_full", 32'(O_Full), 32'd0);
    check("drain_empty", 32'(O_Empty), 32'd1);
    check("drain_log_n", 32'(cq.size()), 32'd8);
    for (int n = 0; n < 8; n++) check($sformatf("drain_log%0d", n), 32'(qat(n)), 32'(n));
    cq.delete();
    drive(1'b1, 7'd20, 16'h0010, '0);
    drive(1'b1, 7'd21, 16'h0020, '0);
    drive(1'b0, '0, '0, 16'h0030);
    cycle();
    cycle();
    cycle();
    check("refill_log_n", 32'(cq.size()), 32'd2);
    check("refill_log0", 32'(qat(0)), 32'd20);
    check("refill_log1", 32'(qat(1)), 32'd21);
    check("refill_empty", 32'(O_Empty), 32'd1);

    // Spurious lane commit into an empty table.
    cq.delete();
    drive(1'b0, '0, '0, 16'h0004);
    cycle();
    check("spur_err", 32'(O_Error), 32'd3);
    check("spur_cnt", 32'(O_Count), 32'd0);
    check("spur_log_n", 32'(cq.size()), 32'd0);

    // Reset mid-flight with partial commits outstanding.
    drive(1'b1, 7'd10, 16'h0003, '0);
    drive(1'b1, 7'd11, 16'h0001, '0);
    drive(1'b1, 7'd12, 16'h0002, '0);
    drive(1'b0, '0, '0, 16'h0001);
    check("mid_cnt", 32'(O_Count), 32'd3);
    cq.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_state("mid_rst");
    cycle();
    cycle();
    check("mid_quiet_n", 32'(cq.size()), 32'd0);
    drive(1'b1, 7'd3, 16'h0001, '0);
    drive(1'b0, '0, '0, 16'h0001);
    cycle();
    cycle();
    cycle();
    check("post_log_n", 32'(cq.size()), 32'd1);
    check("post_log0", 32'(qat(0)), 32'd3);
    check("post_err", 32'(O_Error), 32'd0);
    check("post_empty", 32'(O_Empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vu_commit_unit.md
Name: vu_commit_unit

Overview:
- Sits between the scalar-unit issue path and the NUM_LANES vector lanes.
- Records every vector instruction issued to the lanes, together with its issue number and its set of participating (enabled) lanes.
- Collects the per-lane commit pulses and retires instructions strictly in issue order, giving the scalar unit one commit pulse per instruction.
- Also reports occupancy and protocol errors.

Parameters:
- NUM_LANES, 16, number of vector lanes.
- DEPTH, 8, maximum outstanding instructions (power of two).
- WIDTH_ISSUE, 7, width of the issue number.
- WIDTH_CNT, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- I_Issue  in  1  instruction issued to the lanes this cycle
- I_Issue_No  in  WIDTH_ISSUE  issue number of the issued instruction
- I_Lane_Mask  in  NUM_LANES  lanes that will execute (and commit) this instruction
- I_Lane_Commit  in  NUM_LANES  per-lane commit pulse (each lane's O_Commit)
- O_Full  out  1  table holds DEPTH entries; issue is not accepted
- O_Empty  out  1  no outstanding instruction
- O_Count  out  WIDTH_CNT  outstanding-entry count
- O_Commit  out  1  one-cycle pulse: the oldest instruction has retired
- O_Commit_No  out  WIDTH_ISSUE  issue number of the retired instruction; valid while O_Commit=1
- O_Error  out  2  sticky: [0] spurious lane commit, [1] issue while full

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values:
  - O_Full=0, O_Empty=1, O_Count=0, O_Commit=0, O_Commit_No=0, O_Error=0.
  - Head/tail pointers 0; all entries invalid.
  - Reset mid-operation discards all outstanding entries; no commit pulse is emitted for them.
- Storage: circular table of DEPTH entries, each holding {issue_no, mask[NUM_LANES], done[NUM_LANES]}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - O_Count is separate and distinguishes full from empty.
- Issue:
  - On the edge where I_Issue=1 and O_Full=0: entry[tail] <= {I_Issue_No, I_Lane_Mask, done=0}, then tail++.
  - O_Full is the registered state (count==DEPTH). An issue while full is dropped, even if a retire happens the same cycle, and sets O_Error[1].
- Lane commit:
  - Each lane retires its own instructions in order.
  - For each lane l with I_Lane_Commit[l]=1, set done[l] of the oldest valid entry (searched from head) with mask[l]=1 and done[l]=0.
  - If no such entry exists, ignore the pulse and set O_Error[0].
  - All lanes update independently in the same cycle.
  - A commit may target an entry being written by the same-cycle issue only from the next cycle onwards.
- Retire:
  - Each cycle, if head is valid and done==mask, retire head: head++, count--, O_Commit<=1, O_Commit_No<=head.issue_no (registered).
  - Otherwise O_Commit<=0.
  - At most one retire per cycle.
  - Entries with mask=0 retire as soon as they are at the head.
- Latency:
  - The final lane commit is sampled at edge t; the done bits update at t; the retire decision is made in cycle t..t+1; O_Commit is high after edge t+1 (2-edge latency).
  - A mask=0 entry issued at edge t produces O_Commit after edge t+1 if it is at the head.
- Simultaneous issue and retire: count is unchanged; both pointers advance.
- Wrap-around: pointer and entry reuse must be correct across DEPTH boundaries. Done bits of a retired entry are cleared when it is rewritten.
- O_Empty=(count==0) and O_Full=(count==DEPTH), both registered alongside count.
- O_Error bits clear only on reset.

Test Plan:
- Basic: issue No=5, mask=0x000F; lanes 0-3 each pulse commit once, with the last at edge t -> O_Commit=1, O_Commit_No=5 after edge t+1 for exactly one cycle; O_Empty returns to 1.
- Ordering: issue No=1 (mask 0x0003) then No=2 (mask 0x0001); lane 0 pulses twice, then lane 1 once -> commits emitted as 1 then 2 on consecutive cycles; No=2 is never emitted before No=1.
- Mask zero: issue No=9, mask=0 into an empty table -> O_Commit with No=9 one edge after issue; no lane activity required.
- Full/overflow: issue 8 entries (No=0..7) with no commits -> O_Full=1, O_Count=8; a 9th issue (No=8) is dropped and O_Error=2'b10; committing all lanes then retires 0..7 in order and the pointers wrap correctly on refill.
- Spurious: with the table empty, pulse I_Lane_Commit=0x0004 -> O_Error[0]=1, no O_Commit, O_Count stays 0.
- Reset mid-flight: 3 outstanding entries, partial commits, then assert reset for one cycle -> all outputs at reset values; a following issue of No=3 with mask 0x0001 plus a lane-0 commit yields a single O_Commit with No=3.
